// File: rtl/tdm_demux8_if.sv
// Serial TDM input and parallel frame output bundle for tdm_demux8.
// master drives the slot line; slave is the demultiplexer.
interface tdm_demux8_if;
   logic       din;
   logic       sync;
   logic       en;
   logic [7:0] dout;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   modport master (
      output din, sync, en,
      input  dout, frame_valid, locked, sync_err
   );

   modport slave (
      input  din, sync, en,
      output dout, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux8.sv
// 8-slot TDM demultiplexer with frame-sync lock tracking and a flywheel
// that tolerates up to MISS_MAX consecutive missing slot-0 markers.
module tdm_demux8 #(
   parameter int MISS_MAX = 2
) (
   input logic          clk,
   input logic          rst,
   tdm_demux8_if.slave  bus
);
   typedef enum logic {HUNT, LOCKED} state_t;

   localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

   state_t     state;
   logic [2:0] cnt;
   logic [6:0] stg;
   logic [2:0] miss;
   logic [7:0] dout;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         cnt         <= 3'd0;
         stg         <= 7'd0;
         miss        <= 3'd0;
         dout        <= 8'h00;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (bus.en) begin
            case (state)
               HUNT: begin
                  if (bus.sync) begin
                     stg[0] <= bus.din;
                     cnt    <= 3'd1;
                     miss   <= 3'd0;
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (cnt == 3'd0) begin
                     if (bus.sync) begin
                        stg[0] <= bus.din;
                        cnt    <= 3'd1;
                        miss   <= 3'd0;
                     end else if (miss < MISS_LIM) begin
                        // Flywheel: keep slot timing and take the bit as slot 0.
                        sync_err <= 1'b1;
                        miss     <= miss + 3'd1;
                        stg[0]   <= bus.din;
                        cnt      <= 3'd1;
                     end else begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                        miss     <= 3'd0;
                        cnt      <= 3'd0;
                     end
                  end else if (bus.sync) begin
                     // Misplaced marker wins over completion: restart the frame here.
                     sync_err <= 1'b1;
                     stg      <= {6'd0, bus.din};
                     cnt      <= 3'd1;
                     miss     <= 3'd0;
                  end else if (cnt == 3'd7) begin
                     dout        <= {bus.din, stg};
                     frame_valid <= 1'b1;
                     cnt         <= 3'd0;
                  end else begin
                     stg[cnt] <= bus.din;
                     cnt      <= cnt + 3'd1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   assign bus.dout        = dout;
   assign bus.frame_valid = frame_valid;
   assign bus.locked      = locked;
   assign bus.sync_err    = sync_err;
endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized and directed bench for tdm_demux8 against a frame-level
// reference model built from a queue of received slot bits.
module tb_tdm_demux8;
   localparam int MISS_MAX = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tdm_demux8_if bus ();

   tdm_demux8 #(.MISS_MAX(MISS_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: bits of the frame in progress, lock flag, miss tally.
   bit         m_bits[$];
   bit         m_lock;
   int         m_miss;
   logic [7:0] m_dout;
   bit         m_fv;
   bit         m_serr;

   task automatic model_reset();
      m_bits.delete();
      m_lock = 0;
      m_miss = 0;
      m_dout = 8'h00;
      m_fv   = 0;
      m_serr = 0;
   endtask

   task automatic model_edge(input bit d, input bit s, input bit e);
      m_fv   = 0;
      m_serr = 0;
      if (!e) return;
      if (!m_lock) begin
         if (s) begin
            m_bits = {d};
            m_lock = 1;
            m_miss = 0;
         end
      end else if (m_bits.size() == 0) begin
         if (s) begin
            m_bits = {d};
            m_miss = 0;
         end else if (m_miss + 1 <= MISS_MAX) begin
            m_serr = 1;
            m_miss++;
            m_bits = {d};
         end else begin
            m_serr = 1;
            m_lock = 0;
            m_miss = 0;
         end
      end else if (s) begin
         m_serr = 1;
         m_bits = {d};
         m_miss = 0;
      end else begin
         m_bits.push_back(d);
         if (m_bits.size() == 8) begin
            for (int k = 0; k < 8; k++) m_dout[k] = m_bits[k];
            m_fv = 1;
            m_bits.delete();
         end
      end
   endtask

   // One clock with the given inputs; tallies any model disagreement.
   task automatic step(input logic d, input logic s, input logic e, inout int mism);
      bus.din  = d;
      bus.sync = s;
      bus.en   = e;
      @(posedge clk);
      model_edge(d, s, e);
      #1;
      if ({bus.dout, bus.frame_valid, bus.locked, bus.sync_err} !==
          {m_dout, m_fv, m_lock, m_serr})
         mism++;
   endtask

   task automatic rst_pulse();
      bus.din  = 1'b1;
      bus.sync = 1'b1;
      bus.en   = 1'b1;
      rst      = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit s0, input int gap,
                             output int fvs, output int errs, output int mism,
                             output bit lk_first);
      fvs = 0; errs = 0; mism = 0; lk_first = 0;
      for (int k = 0; k < 8; k++) begin
         step(b[k], s0 && (k == 0), 1'b1, mism);
         if (k == 0) lk_first = bus.locked;
         fvs  += int'(bus.frame_valid);
         errs += int'(bus.sync_err);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 1'b0, mism);
            fvs  += int'(bus.frame_valid);
            errs += int'(bus.sync_err);
         end
      end
   endtask

   task automatic test_reset();
      rst_pulse();
      checks++;
      if ({bus.dout, bus.frame_valid, bus.locked, bus.sync_err} !== 11'h000) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 000",
                  {bus.dout, bus.frame_valid, bus.locked, bus.sync_err});
      end
   endtask

   task automatic test_basic();
      int fvs, errs, mism;
      bit lk;
      rst_pulse();
      send_frame(8'hA5, 1, 0, fvs, errs, mism, lk);
      checks++;
      if (lk !== 1'b1) begin errors++; $display("FAIL basic_lock_rise: got %b want 1", lk); end
      checks++;
      if (bus.dout !== 8'hA5 || bus.frame_valid !== 1'b1) begin
         errors++; $display("FAIL basic_a5: got %h/%b want a5/1", bus.dout, bus.frame_valid);
      end
      send_frame(8'h3C, 1, 0, fvs, errs, mism, lk);
      checks++;
      if (bus.dout !== 8'h3C || fvs !== 1 || errs !== 0 || mism !== 0) begin
         errors++;
         $display("FAIL basic_3c: got %h fv=%0d err=%0d mism=%0d want 3c 1 0 0",
                  bus.dout, fvs, errs, mism);
      end
      mism = 0;
      step(1'b0, 1'b0, 1'b0, mism);
      checks++;
      if (bus.frame_valid !== 1'b0 || mism !== 0) begin
         errors++; $display("FAIL basic_fv_single: got fv=%b want 0", bus.frame_valid);
      end
   endtask

   task automatic test_sparse_en();
      int fvs, errs, mism;
      bit lk;
      rst_pulse();
      send_frame(8'hA5, 1, 2, fvs, errs, mism, lk);
      checks++;
      if (bus.dout !== 8'hA5 || fvs !== 1 || mism !== 0) begin
         errors++;
         $display("FAIL sparse_en: got %h fv=%0d mism=%0d want a5 1 0", bus.dout, fvs, mism);
      end
   endtask

   task automatic test_misplaced();
      int fvs, errs, mism;
      bit lk;
      logic [6:0] tail;
      tail = 7'b1000110;  // 0,1,1,0,0,0,1 applied LSB first
      rst_pulse();
      send_frame(8'hA5, 1, 0, fvs, errs, mism, lk);
      fvs = 0; mism = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, k == 0, 1'b1, mism);
         fvs += int'(bus.frame_valid);
      end
      fvs = 0;
      step(1'b1, 1'b1, 1'b1, mism);
      checks++;
      if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.locked !== 1'b1) begin
         errors++;
         $display("FAIL misplaced_err: got err=%b fv=%b lk=%b want 1 0 1",
                  bus.sync_err, bus.frame_valid, bus.locked);
      end
      for (int k = 0; k < 7; k++) begin
         step(tail[k], 1'b0, 1'b1, mism);
         fvs += int'(bus.frame_valid);
      end
      checks++;
      if (bus.dout !== 8'h8D || fvs !== 1 || mism !== 0) begin
         errors++;
         $display("FAIL misplaced_realign: got %h fv=%0d mism=%0d want 8d 1 0", bus.dout, fvs, mism);
      end
   endtask

   task automatic test_flywheel();
      int fvs, errs, mism;
      bit lk;
      rst_pulse();
      send_frame(8'hA5, 1, 0, fvs, errs, mism, lk);
      for (int n = 0; n < MISS_MAX; n++) begin
         send_frame(8'hFF, 0, 0, fvs, errs, mism, lk);
         checks++;
         if (bus.dout !== 8'hFF || fvs !== 1 || errs !== 1 || bus.locked !== 1'b1 || mism !== 0) begin
            errors++;
            $display("FAIL flywheel_miss%0d: got %h fv=%0d err=%0d lk=%b want ff 1 1 1",
                     n, bus.dout, fvs, errs, bus.locked);
         end
      end
      send_frame(8'h00, 0, 0, fvs, errs, mism, lk);
      checks++;
      if (lk !== 1'b0 || bus.locked !== 1'b0 || fvs !== 0 || errs !== 1 || bus.dout !== 8'hFF) begin
         errors++;
         $display("FAIL flywheel_drop: got lk=%b fv=%0d err=%0d dout=%h want 0 0 1 ff",
                  bus.locked, fvs, errs, bus.dout);
      end
      send_frame(8'h69, 1, 0, fvs, errs, mism, lk);
      checks++;
      if (bus.dout !== 8'h69 || fvs !== 1 || mism !== 0) begin
         errors++; $display("FAIL flywheel_relock: got %h fv=%0d want 69 1", bus.dout, fvs);
      end
   endtask

   task automatic test_hunt();
      int fvs, mism;
      rst_pulse();
      fvs = 0; mism = 0;
      for (int k = 0; k < 20; k++) begin
         step(k[0], 1'b0, 1'b1, mism);
         fvs += int'(bus.frame_valid);
      end
      checks++;
      if (bus.locked !== 1'b0 || fvs !== 0 || bus.dout !== 8'h00 || mism !== 0) begin
         errors++;
         $display("FAIL hunt_ignore: got lk=%b fv=%0d dout=%h want 0 0 00", bus.locked, fvs, bus.dout);
      end
      step(1'b1, 1'b1, 1'b0, mism);
      step(1'b0, 1'b0, 1'b1, mism);
      checks++;
      if (bus.locked !== 1'b0 || mism !== 0) begin
         errors++; $display("FAIL hunt_en_low_sync: got lk=%b want 0", bus.locked);
      end
   endtask

   task automatic test_mid_reset();
      int fvs, errs, mism;
      bit lk;
      rst_pulse();
      send_frame(8'hC3, 1, 0, fvs, errs, mism, lk);
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, mism);
      rst_pulse();
      checks++;
      if ({bus.dout, bus.frame_valid, bus.locked, bus.sync_err} !== 11'h000) begin
         errors++;
         $display("FAIL midreset_clear: got %h want 000",
                  {bus.dout, bus.frame_valid, bus.locked, bus.sync_err});
      end
      send_frame(8'h5A, 1, 0, fvs, errs, mism, lk);
      checks++;
      if (bus.dout !== 8'h5A || fvs !== 1 || mism !== 0) begin
         errors++; $display("FAIL midreset_relock: got %h fv=%0d want 5a 1", bus.dout, fvs);
      end
   endtask

   task automatic test_random();
      int mism;
      logic s;
      rst_pulse();
      mism = 0;
      for (int k = 0; k < 1500; k++) begin
         s = (m_bits.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         step(1'($urandom), s, $urandom_range(0, 3) != 0, mism);
      end
      checks++;
      if (mism !== 0) begin
         errors++; $display("FAIL random_model: got %0d disagreements want 0", mism);
      end
   endtask

   initial begin
      bus.din  = 1'b0;
      bus.sync = 1'b0;
      bus.en   = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_sparse_en();
      test_misplaced();
      test_flywheel();
      test_hunt();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Time-division demultiplexer that undoes 8:1 slot multiplexing. It takes one serial line carrying 8 time slots per frame, plus a frame-sync marker, and writes each slot bit to its own parallel output bit. It tracks frame alignment with a lock state machine and a flywheel miss counter. Each completed 8-slot frame is presented as a registered byte with a one-cycle valid strobe. It sits at the receive end of a link fed by the 8-input mux path.

## Interface
- MISS_MAX, 2, number of consecutive missing slot-0 syncs tolerated while locked before lock is dropped (range 1..7)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial TDM data bit for the current slot
- sync  input  1  frame marker; high together with the slot-0 bit
- en  input  1  slot strobe; din/sync sampled only on edges where en=1
- dout  output  8  last complete frame; slot k maps to dout[k]
- frame_valid  output  1  one-cycle pulse; a new frame was just loaded into dout
- locked  output  1  high while frame alignment is held
- sync_err  output  1  one-cycle pulse on a missed or misplaced sync

## Operation
- Internal state: FSM {HUNT, LOCKED}, 3-bit slot counter cnt, 7-bit staging register stg, miss counter (3 bits wide).
- Reset (rst=1 at an edge) forces: state=HUNT, cnt=0, stg=0, miss=0. Outputs: dout=8'h00, frame_valid=0, locked=0, sync_err=0. Reset overrides all other inputs. Reset mid-frame discards the partial frame.
- Edges with en=0: no state change. frame_valid and sync_err return to 0.
- HUNT state, en=1:
  - sync=0: din is ignored.
  - sync=1: stg[0]<=din, cnt<=1, miss<=0, state<=LOCKED, locked<=1.
- LOCKED state, en=1, cnt=1..6:
  - sync=0: stg[cnt]<=din, cnt<=cnt+1.
- LOCKED state, en=1, cnt=7:
  - sync=0: dout<={din, stg[6:0]}, frame_valid<=1, cnt<=0 (wraps).
- LOCKED state, en=1, sync=1 at cnt≠0 (misplaced sync):
  - sync_err<=1.
  - Realign: stg cleared, stg[0]<=din, cnt<=1, miss<=0.
  - Partial frame discarded, no frame_valid. locked stays 1.
  - At cnt=7 the realign takes priority over frame completion.
- LOCKED state, en=1, cnt=0 (expected slot 0):
  - sync=1: stg[0]<=din, cnt<=1, miss<=0.
  - sync=0 and miss+1 ≤ MISS_MAX (flywheel): sync_err<=1, miss<=miss+1. The bit is still captured as slot 0 and cnt<=1.
  - sync=0 and miss+1 > MISS_MAX: sync_err<=1, state<=HUNT, locked<=0, miss<=0, cnt<=0. The bit is discarded.
- dout holds its value between frames and through loss of lock. It changes only on frame completion or reset.

## Timing
- All outputs are registered and change only on rising clk edges.
- Latency: the edge that samples the slot-7 bit (en=1) loads dout. frame_valid is high for exactly the following cycle.
- locked rises in the cycle after the first sync edge in HUNT. It falls in the cycle after the edge that exceeds MISS_MAX.
- sync_err is a single-cycle pulse per offending en edge.
- There is no back-pressure. dout must be consumed within 8 en strobes.
- Maximum frame rate: one frame every 8 cycles (en tied high). frame_valid pulses can then be 8 cycles apart, never adjacent.

## Test plan
- Reset, then en=1 continuous. Sync with slot 0. Slot bits for 0xA5, slot 0 first: 1,0,1,0,0,1,0,1. Required: locked=1 one cycle after the sync edge. dout=8'hA5 with a frame_valid pulse one cycle after the slot-7 edge. A second frame of 0x3C gives dout=8'h3C.
- Same 0xA5 frame with en asserted every third cycle. Required: the same dout, and exactly one frame_valid pulse per frame.
- Locked, 4 slots into a frame, sync asserted at slot 4 with din=1. Required: sync_err pulse, no frame_valid for the partial frame. The next 7 bits 0,1,1,0,0,0,1 give dout=8'h8D.
- MISS_MAX=2, locked. Omit sync on two consecutive frames of 0xFF. Required: two sync_err pulses, dout=8'hFF delivered both times, locked=1. Omit a third time. Required: sync_err, locked=0, no frame_valid until a new sync plus 8 slots.
- In HUNT, drive din toggling with sync=0 for 20 en edges. Required: locked=0, no frame_valid, dout unchanged. Also assert sync with en=0. Required: still HUNT.
- After 5 slots of a locked frame, pulse rst for one cycle. Required: dout=8'h00, frame_valid=0, locked=0, sync_err=0 the next cycle. A fresh sync relocks and 0x5A is delivered correctly.
